// File: rtl/clock_divider.sv
// Integer clock divider: clock_out period = max(DIVISOR,2) clock_in cycles, registered outputs, tick per period.
// Optional CLOCK_DIVIDER_DUTY50_EN adds a falling-edge flop so odd divisors give 50% duty.
module clock_divider #(
  parameter logic [27:0] DIVISOR = 28'd2
) (
  input  logic        clock_in,
  input  logic        rst,
  input  logic        en,
  output logic        clock_out,
  output logic        tick,
  output logic [27:0] cnt
);

  // Divisors below 2 cannot produce a toggling output, so they collapse to 2.
  localparam logic [27:0] N    = (DIVISOR < 28'd2) ? 28'd2 : DIVISOR;
  localparam logic [27:0] HALF = N >> 1;
  localparam logic [27:0] LAST = N - 28'd1;

  logic [27:0] r_cnt;
  logic        r_clk;
  logic        r_tick;
  logic [27:0] w_cnt_next;

  assign w_cnt_next = (r_cnt == LAST) ? 28'd0 : r_cnt + 28'd1;

  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      r_cnt  <= 28'd0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else if (en) begin
      r_cnt  <= w_cnt_next;
      r_clk  <= (w_cnt_next >= HALF);
      r_tick <= (w_cnt_next == 28'd0);
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign cnt  = r_cnt;
  assign tick = r_tick;

`ifdef CLOCK_DIVIDER_DUTY50_EN
  generate
    if (N[0]) begin : g_duty50
      // Half-cycle delayed copy trims the extra high half-cycle of odd divisors.
      logic r_clk_neg;
      always_ff @(negedge clock_in or posedge rst) begin
        if (rst) r_clk_neg <= 1'b0;
        else     r_clk_neg <= r_clk;
      end
      assign clock_out = r_clk & r_clk_neg;
    end else begin : g_even
      assign clock_out = r_clk;
    end
  endgenerate
`else
  assign clock_out = r_clk;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Randomized scoreboard bench for clock_divider over divisors 4, 3, 0, 1 and 8.
`timescale 1ns/1ps
module tb_clock_divider;

`ifdef CLOCK_DIVIDER_DUTY50_EN
  localparam bit DUTY50 = 1'b1;
`else
  localparam bit DUTY50 = 1'b0;
`endif

  localparam int NI = 5;

  logic clock_in;
  logic rst;
  logic en;
  wire [NI-1:0]        dut_clk;
  wire [NI-1:0]        dut_tick;
  wire [NI-1:0][27:0]  dut_cnt;

  clock_divider #(28'd4) u_d4 (.clock_in(clock_in), .rst(rst), .en(en),
    .clock_out(dut_clk[0]), .tick(dut_tick[0]), .cnt(dut_cnt[0]));
  clock_divider #(28'd3) u_d3 (.clock_in(clock_in), .rst(rst), .en(en),
    .clock_out(dut_clk[1]), .tick(dut_tick[1]), .cnt(dut_cnt[1]));
  clock_divider #(28'd0) u_d0 (.clock_in(clock_in), .rst(rst), .en(en),
    .clock_out(dut_clk[2]), .tick(dut_tick[2]), .cnt(dut_cnt[2]));
  clock_divider #(28'd1) u_d1 (.clock_in(clock_in), .rst(rst), .en(en),
    .clock_out(dut_clk[3]), .tick(dut_tick[3]), .cnt(dut_cnt[3]));
  clock_divider #(28'd8) u_d8 (.clock_in(clock_in), .rst(rst), .en(en),
    .clock_out(dut_clk[4]), .tick(dut_tick[4]), .cnt(dut_cnt[4]));

  initial begin
    clock_in = 1'b0;
    forever #12.5 clock_in = ~clock_in;
  end

  typedef struct {
    realtime             t;
    logic [NI-1:0]       clk;
    logic [NI-1:0]       tick;
    logic [NI-1:0][27:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: phase within the period, output level, last tick, level at previous falling edge.
  int n [NI] = '{4, 3, 2, 2, 8};
  int ph[NI];
  bit lvl[NI];
  bit tk[NI];
  bit old[NI];

  function automatic exp_t snapshot(input realtime t);
    exp_t e;
    e.t = t;
    for (int i = 0; i < NI; i++) begin
      e.cnt[i]  = 28'(ph[i]);
      e.tick[i] = tk[i];
      e.clk[i]  = (DUTY50 && (n[i] % 2 == 1)) ? (lvl[i] & old[i]) : lvl[i];
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      ph[i] = 0; lvl[i] = 1'b0; tk[i] = 1'b0; old[i] = 1'b0;
    end
  endtask

  // Drive one cycle's inputs at the falling edge and predict the state after the next rising edge.
  task automatic step(input bit r, input bit e);
    @(negedge clock_in);
    rst = r;
    en  = e;
    if (r) model_reset();
    else begin
      for (int i = 0; i < NI; i++) begin
        old[i] = lvl[i];
        if (e) begin
          ph[i]  = (ph[i] + 1) % n[i];
          // Low for the first floor(N/2) phases of each period, high for the remaining ceil(N/2).
          lvl[i] = (ph[i] >= n[i] - (n[i] + 1) / 2);
          tk[i]  = (ph[i] == 0);
        end else begin
          tk[i] = 1'b0;
        end
      end
    end
    sb.push_back(snapshot($realtime + 14.5));
  endtask

  // Monitor: pops each expectation and samples the DUT at its scheduled time.
  initial begin
    exp_t e;
    forever begin
      wait (sb.size() != 0);
      e = sb.pop_front();
      if (e.t > $realtime) #(e.t - $realtime);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (dut_cnt[i] !== e.cnt[i]) begin
          failures++;
          $display("FAIL cnt[%0d] t=%0t got=%0d want=%0d", i, $realtime, dut_cnt[i], e.cnt[i]);
        end
        checks++;
        if (dut_clk[i] !== e.clk[i]) begin
          failures++;
          $display("FAIL clock_out[%0d] t=%0t got=%b want=%b", i, $realtime, dut_clk[i], e.clk[i]);
        end
        checks++;
        if (dut_tick[i] !== e.tick[i]) begin
          failures++;
          $display("FAIL tick[%0d] t=%0t got=%b want=%b", i, $realtime, dut_tick[i], e.tick[i]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    model_reset();
    sb.push_back(snapshot(5.0));
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // Release and free-run: first rise for N=4 on the second edge, tick every N cycles.
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1);

    // Freeze the N=4 divider at cnt=2 for five cycles, then resume.
    for (int k = 0; k < 8 && ph[0] != 2; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1);

    // Asynchronous reset between edges while the N=8 output is high.
    for (int k = 0; k < 16 && ph[4] != 5; k++) step(1'b0, 1'b1);
    @(posedge clock_in);
    #5 rst = 1'b1;
    model_reset();
    sb.push_back(snapshot($realtime + 1.0));
    #2 rst = 1'b0;
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1);

    // Randomized enable and occasional synchronous-looking reset pulses.
    for (int k = 0; k < 500; k++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) != 0));

    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clock_in);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    #40;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
